instr_imm_encoder: RTL and testbench

//  Encoder counterpart to the immediate generator: packs register fields and a 64-bit

---
 rtl/instr_imm_encoder_pkg.sv | 19 +
 rtl/instr_imm_encoder_imm_range_check.sv | 12 +
 rtl/instr_imm_encoder.sv | 86 ++++++++
 tb/tb_instr_imm_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/instr_imm_encoder_pkg.sv
// instr_imm_encoder_pkg: format/opcode codes shared by the immediate encoder and its range checker
package instr_imm_encoder_pkg;
    localparam logic [1:0] FMT_I   = 2'b00;
    localparam logic [1:0] FMT_S   = 2'b01;
    localparam logic [1:0] FMT_SB  = 2'b10;
    localparam logic [1:0] FMT_RSV = 2'b11;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Only opcode[6:5] distinguishes the major class; the reserved format never matches.
    function automatic logic opc_ok(input logic [1:0] fmt, input logic [6:0] opcode);
        return fmt == FMT_I  ? opcode[6:5] == OPC_LOAD[6:5]   :
               fmt == FMT_S  ? opcode[6:5] == OPC_STORE[6:5]  :
               fmt == FMT_SB ? opcode[6:5] == OPC_BRANCH[6:5] : 1'b0;
    endfunction
endpackage

// File: rtl/instr_imm_encoder_imm_range_check.sv
// imm_range_check: does a 64-bit sign-extended immediate fit its format's field, and is it aligned
module imm_range_check
    import instr_imm_encoder_pkg::*;
(
    input  logic [63:0] imm,
    input  logic [1:0]  fmt,
    output logic        fits,
    output logic        aligned
);
    assign fits    = fmt == FMT_SB ? (&imm[63:12] | ~|imm[63:12]) : (&imm[63:11] | ~|imm[63:11]);
    assign aligned = fmt != FMT_SB | !imm[0];
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: packs I/S/SB instruction words, streams them with load addresses, rejects bad requests
module instr_imm_encoder
    import instr_imm_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [63:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic                 fits, aligned, good, acc, take;
    logic [31:0]          enc;
    logic                 out_valid_q, out_valid_d, err_pulse_q, err_pulse_d;
    logic [31:0]          instr_q, instr_d;
    logic [ADDR_W-1:0]    out_addr_q, out_addr_d, nxt_q, nxt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    imm_range_check u_range (
        .imm     (imm),
        .fmt     (fmt),
        .fits    (fits),
        .aligned (aligned)
    );

    assign in_ready = !out_valid_q | out_ready;
    assign acc      = in_valid & in_ready;
    assign good     = fits & aligned & opc_ok(fmt, opcode);
    assign take     = acc & good & !clear;

    always_comb begin
        enc = fmt == FMT_I ? {imm[11:0], rs1, funct3, rd, opcode} :
              fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                             {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
    end

    // A rejected request still drains the slot, so acc alone decides the new valid.
    always_comb begin
        out_valid_d = clear ? 1'b0 : acc ? good : out_valid_q & !out_ready;
        instr_d     = take ? enc : instr_q;
        out_addr_d  = clear ? BASE_ADDR : take ? nxt_q : out_addr_q;
        nxt_d       = clear ? BASE_ADDR : take ? nxt_q + ADDR_W'(4) : nxt_q;
        err_pulse_d = acc & !good & !clear;
        err_cnt_d   = clear ? '0 : (err_pulse_d & ~&err_cnt_q) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            out_addr_q  <= BASE_ADDR;
            nxt_q       <= BASE_ADDR;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            out_addr_q  <= out_addr_d;
            nxt_q       <= nxt_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign out_addr  = out_addr_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb_instr_imm_encoder: directed and random requests, expected words queued and checked by a negedge monitor
module tb_instr_imm_encoder;
    import instr_imm_encoder_pkg::*;

    localparam int AW = 4;
    localparam int EW = 2;

    logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]    fmt = '0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [63:0]   imm = '0;
    logic          in_ready, out_valid, err_pulse;
    logic [31:0]   instr;
    logic [AW-1:0] out_addr;
    logic [EW-1:0] err_cnt;

    instr_imm_encoder #(.ADDR_W(AW), .BASE_ADDR('0), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
    } item_t;

    item_t         sb[$];
    logic [AW-1:0] m_nxt = '0;
    logic [EW-1:0] m_cnt = '0;
    logic          m_pulse = 1'b0;
    bit            run = 1'b0;
    int            errors = 0, checks = 0;
    longint        bnd[10] = '{2047, -2048, 2048, -2049, 4094, 4095, -4096, -4097, 4096, -4098};

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic bit m_good(input logic [1:0] f, input logic [6:0] op, input logic [63:0] im);
        longint s = longint'(im);
        int cls = int'(op) / 32;
        case (f)
            FMT_I:   return cls == 0 && s >= -2048 && s <= 2047;
            FMT_S:   return cls == 1 && s >= -2048 && s <= 2047;
            FMT_SB:  return cls == 3 && s >= -4096 && s <= 4095 && s % 2 == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_enc(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [63:0] im);
        case (f)
            FMT_I:   return {im[11:0], s1, f3, d, op};
            FMT_S:   return {im[11:5], s2, s1, f3, im[4:0], op};
            default: return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        endcase
    endfunction

    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("err_pulse", err_pulse, m_pulse);
            chk("err_cnt", err_cnt, m_cnt);
            chk("out_valid", out_valid, sb.size() != 0);
            if (out_valid && sb.size() != 0) begin
                chk("instr", instr, sb[0].instr);
                chk("out_addr", out_addr, sb[0].addr);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1 with the model advanced.
    task automatic cyc(input logic v, input logic c, input logic r, input logic [1:0] f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [63:0] im, input logic [32:0] ovr);
        bit    ir, acc;
        item_t it;
        in_valid = v; clear = c; out_ready = r; fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
        #6;
        ir  = sb.size() == 0 || r;
        acc = v && ir;
        chk("in_ready", in_ready, ir);
        @(posedge clk);
        m_pulse = 1'b0;
        if (c) begin
            sb.delete();
            m_nxt = '0;
            m_cnt = '0;
        end else if (acc) begin
            if (m_good(f, op, im)) begin
                it.instr = ovr[32] ? ovr[31:0] : m_enc(f, op, f3, d, s1, s2, im);
                it.addr  = m_nxt;
                sb.push_back(it);
                m_nxt += AW'(4);
            end else begin
                m_pulse = 1'b1;
                if (m_cnt != {EW{1'b1}}) m_cnt++;
            end
        end
        #1;
    endtask

    task automatic rnd_cyc();
        logic [1:0]  f;
        logic [6:0]  op;
        logic [63:0] im;
        longint      t;
        f = $urandom_range(0, 9) == 0 ? FMT_RSV : 2'($urandom_range(0, 2));
        case (f)
            FMT_I:   op = $urandom_range(0, 1) ? OPC_LOAD : OPC_OPIMM;
            FMT_S:   op = OPC_STORE;
            default: op = OPC_BRANCH;
        endcase
        if ($urandom_range(0, 6) == 0) op = 7'($urandom);
        case ($urandom_range(0, 3))
            0: begin t = longint'($urandom_range(0, 10000)) - 5000; im = t; end
            1: begin t = bnd[$urandom_range(0, 9)]; im = t; end
            2: im = {$urandom, $urandom};
            default: im = {{52{1'b0}}, 12'($urandom)} - 64'd2048;
        endcase
        cyc($urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, f, op,
            3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        run = 1'b1;
        cyc(1, 0, 1, FMT_I, OPC_OPIMM, 0, 5, 0, 0, -1, {1'b1, 32'hFFF00293});
        cyc(1, 0, 1, FMT_S, OPC_STORE, 3, 0, 1, 2, 8, {1'b1, 32'h0020B423});
        cyc(1, 0, 1, FMT_SB, OPC_BRANCH, 0, 0, 1, 2, -4, {1'b1, 32'hFE208EE3});
        cyc(1, 0, 1, FMT_I, OPC_LOAD, 0, 1, 2, 0, 2048, '0);
        cyc(1, 0, 1, FMT_SB, OPC_BRANCH, 1, 0, 3, 4, 3, '0);
        cyc(1, 0, 1, FMT_S, OPC_OPIMM, 2, 0, 5, 6, 0, '0);
        chk("err_cnt_three", err_cnt, 3);
        cyc(1, 0, 1, FMT_RSV, OPC_LOAD, 0, 1, 1, 1, 0, '0);
        chk("err_cnt_sat", err_cnt, 3);
        cyc(1, 0, 1, FMT_I, OPC_LOAD, 2, 7, 8, 0, 2047, '0);
        cyc(1, 0, 0, FMT_SB, OPC_BRANCH, 1, 0, 9, 10, -4096, '0);
        repeat (3) cyc(1, 0, 0, FMT_S, OPC_STORE, 1, 0, 11, 12, -2048, '0);
        cyc(1, 0, 1, FMT_S, OPC_STORE, 1, 0, 11, 12, -2048, '0);
        cyc(1, 0, 0, FMT_I, OPC_OPIMM, 4, 13, 14, 0, 100, '0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_out_addr", out_addr, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        sb.delete();
        m_nxt = '0;
        m_cnt = '0;
        m_pulse = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 1, FMT_I, OPC_LOAD, 0, 1, 2, 0, 4, '0);
        cyc(1, 0, 1, FMT_I, OPC_LOAD, 0, 1, 2, 0, 4096, '0);
        cyc(1, 0, 0, FMT_S, OPC_STORE, 0, 0, 3, 4, 5, '0);
        cyc(1, 1, 1, FMT_I, OPC_OPIMM, 0, 5, 6, 0, 7, '0);
        chk("clear_err_cnt", err_cnt, 0);
        cyc(1, 1, 1, FMT_RSV, OPC_LOAD, 0, 0, 0, 0, 0, '0);
        repeat (5) cyc(1, 0, 1, FMT_I, OPC_OPIMM, 1, 2, 3, 0, 9, '0);
        repeat (400) rnd_cyc();
        repeat (3) cyc(0, 0, 1, FMT_I, OPC_LOAD, 0, 0, 0, 0, 0, '0);
        chk("drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
